// File: rtl/chain_pkg.sv
// Shared widths, sentinels, FSM encoding and the saturating adder for the chaining DP stage.
package chain_pkg;

    localparam int CHAIN_SCORE_W = 32;
    localparam int CHAIN_IDX_W   = 16;

    localparam logic [CHAIN_SCORE_W-1:0] NEG_INF   = {1'b1, {(CHAIN_SCORE_W-1){1'b0}}};
    localparam logic [CHAIN_SCORE_W-1:0] SCORE_MAX = {1'b0, {(CHAIN_SCORE_W-1){1'b1}}};
    localparam logic [CHAIN_IDX_W-1:0]   NO_PRED   = {CHAIN_IDX_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    // Add one guard bit, then clamp back into the signed SCORE_W range.
    function automatic logic signed [CHAIN_SCORE_W-1:0] sat_add(
        input logic signed [CHAIN_SCORE_W-1:0] a,
        input logic signed [CHAIN_SCORE_W-1:0] b
    );
        logic signed [CHAIN_SCORE_W:0] s;
        s = {a[CHAIN_SCORE_W-1], a} + {b[CHAIN_SCORE_W-1], b};
        if (s[CHAIN_SCORE_W] != s[CHAIN_SCORE_W-1])
            return s[CHAIN_SCORE_W] ? NEG_INF : SCORE_MAX;
        return s[CHAIN_SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/chain_f_ring.sv
// Ring of the most recent f values: one synchronous write port, one combinational read port.
module chain_f_ring #(
    parameter int DEPTH = 64,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);

    // Never reset: stale entries are masked upstream by the distance check.
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i)
            mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/chain_dp_max.sv
// Chaining DP max stage: f(i) = max(w_i, max_j f(j)+score(j,i)) with best predecessor tracking.
module chain_dp_max
    import chain_pkg::*;
#(
    parameter int MAX_PRED = 64,
    parameter int IDX_W    = CHAIN_IDX_W,   // must match package width (sat_add/sentinels)
    parameter int SCORE_W  = CHAIN_SCORE_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               chain_clear,
    input  logic               anchor_valid,
    output logic               anchor_ready,
    input  logic [SCORE_W-1:0] anchor_w,
    input  logic               anchor_nopred,
    input  logic               score_valid,
    output logic               score_ready,
    input  logic [SCORE_W-1:0] score_val,
    input  logic [IDX_W-1:0]   score_dist,
    input  logic               score_last,
    output logic               f_valid,
    input  logic               f_ready,
    output logic [SCORE_W-1:0] f_score,
    output logic [IDX_W-1:0]   f_pred,
    output logic [IDX_W-1:0]   f_idx
);

    localparam int                AW   = $clog2(MAX_PRED);
    localparam logic [IDX_W-1:0]  MAXP = IDX_W'(MAX_PRED);

    state_t state_q, state_d;

    logic [IDX_W-1:0]          i_q, i_d;
    logic signed [SCORE_W-1:0] best_q, best_d;
    logic [IDX_W-1:0]          pred_q, pred_d;
    logic [SCORE_W-1:0]        f_score_q, f_score_d;
    logic [IDX_W-1:0]          f_pred_q, f_pred_d;
    logic [IDX_W-1:0]          f_idx_q, f_idx_d;

    logic                      beat_ok, beat_upd, emit_enter;
    logic [AW-1:0]             rd_addr;
    logic [SCORE_W-1:0]        rd_data;
    logic signed [SCORE_W-1:0] cand;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (anchor_valid) state_d = anchor_nopred ? EMIT : ACCUM;
            ACCUM:   if (score_valid && score_last) state_d = EMIT;
            EMIT:    if (f_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        anchor_ready = (state_q == IDLE);
        score_ready  = (state_q == ACCUM);
        f_valid      = (state_q == EMIT);
    end

    // Predecessor f lookup; the ring address is just the low bits of i-dist.
    assign rd_addr = i_q[AW-1:0] - score_dist[AW-1:0];
    assign cand    = sat_add(rd_data, score_val);

    // Stale or out-of-window predecessors are masked here rather than by clearing the ring.
    assign beat_ok  = (score_val != NEG_INF) && (score_dist != '0) &&
                      (score_dist <= MAXP) && (score_dist <= i_q);
    assign beat_upd = (state_q == ACCUM) && score_valid && beat_ok && (cand > best_q);

    assign emit_enter = (state_q != EMIT) && (state_d == EMIT);

    always_comb begin
        i_d    = i_q;
        best_d = best_q;
        pred_d = pred_q;
        case (state_q)
            IDLE: begin
                if (chain_clear) i_d = '0;
                if (anchor_valid) begin
                    best_d = anchor_w;
                    pred_d = NO_PRED;
                end
            end
            ACCUM: begin
                if (beat_upd) begin
                    best_d = cand;
                    pred_d = i_q - score_dist;
                end
            end
            EMIT:    if (f_ready) i_d = i_q + 1'b1;
            default: ;
        endcase
    end

    // Result registers capture the final best on the edge that enters EMIT.
    always_comb begin
        f_score_d = f_score_q;
        f_pred_d  = f_pred_q;
        f_idx_d   = f_idx_q;
        if (emit_enter) begin
            f_score_d = best_d;
            f_pred_d  = pred_d;
            f_idx_d   = i_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            i_q       <= '0;
            best_q    <= '0;
            pred_q    <= NO_PRED;
            f_score_q <= '0;
            f_pred_q  <= NO_PRED;
            f_idx_q   <= '0;
        end else begin
            i_q       <= i_d;
            best_q    <= best_d;
            pred_q    <= pred_d;
            f_score_q <= f_score_d;
            f_pred_q  <= f_pred_d;
            f_idx_q   <= f_idx_d;
        end
    end

    assign f_score = f_score_q;
    assign f_pred  = f_pred_q;
    assign f_idx   = f_idx_q;

    // Write lands on the EMIT entry edge, so the next anchor's dist=1 read sees it.
    chain_f_ring #(
        .DEPTH (MAX_PRED),
        .W     (SCORE_W)
    ) u_ring (
        .clk     (clk),
        .we_i    (emit_enter && !reset),
        .waddr_i (i_d[AW-1:0]),
        .wdata_i (best_d),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

endmodule

// File: tb/tb_chain_dp_max.sv
// Directed bench for chain_dp_max: table of anchor records plus hand sequences for corner cases.
module tb_chain_dp_max;

    logic        clk = 1'b0;
    logic        reset;
    logic        chain_clear;
    logic        anchor_valid;
    logic        anchor_ready;
    logic [31:0] anchor_w;
    logic        anchor_nopred;
    logic        score_valid;
    logic        score_ready;
    logic [31:0] score_val;
    logic [15:0] score_dist;
    logic        score_last;
    logic        f_valid;
    logic        f_ready;
    logic [31:0] f_score;
    logic [15:0] f_pred;
    logic [15:0] f_idx;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    chain_dp_max dut (
        .clk           (clk),
        .reset         (reset),
        .chain_clear   (chain_clear),
        .anchor_valid  (anchor_valid),
        .anchor_ready  (anchor_ready),
        .anchor_w      (anchor_w),
        .anchor_nopred (anchor_nopred),
        .score_valid   (score_valid),
        .score_ready   (score_ready),
        .score_val     (score_val),
        .score_dist    (score_dist),
        .score_last    (score_last),
        .f_valid       (f_valid),
        .f_ready       (f_ready),
        .f_score       (f_score),
        .f_pred        (f_pred),
        .f_idx         (f_idx)
    );

    typedef struct {
        logic [31:0] w;
        logic        np;
        logic        clr;
        int          nb;
        logic [31:0] sv [3];
        logic [15:0] sd [3];
        logic [31:0] ef;
        logic [15:0] ep;
        logic [15:0] ei;
    } vec_t;

    vec_t tab1[$];
    vec_t tab2[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [31:0] w, input logic np, input logic clr, input int nb,
                                 input logic [31:0] s0, input logic [15:0] d0,
                                 input logic [31:0] s1, input logic [15:0] d1,
                                 input logic [31:0] s2, input logic [15:0] d2,
                                 input logic [31:0] ef, input logic [15:0] ep, input logic [15:0] ei);
        vec_t v;
        v.w = w; v.np = np; v.clr = clr; v.nb = nb;
        v.sv[0] = s0; v.sd[0] = d0;
        v.sv[1] = s1; v.sd[1] = d1;
        v.sv[2] = s2; v.sd[2] = d2;
        v.ef = ef; v.ep = ep; v.ei = ei;
        return v;
    endfunction

    task automatic send_anchor(input logic [31:0] w, input logic np, input logic clr);
        int n = 0;
        @(negedge clk);
        anchor_valid = 1'b1; anchor_w = w; anchor_nopred = np; chain_clear = clr;
        while (!anchor_ready && n < 20) begin @(negedge clk); n++; end
        chk("anchor_ready_wait", 32'(anchor_ready), 32'd1);
        @(posedge clk); #1;
        anchor_valid = 1'b0; chain_clear = 1'b0; anchor_nopred = 1'b0;
        chk("anchor_lat", 32'(f_valid), 32'(np));
    endtask

    task automatic send_beat(input logic [31:0] s, input logic [15:0] d, input logic last);
        int n = 0;
        @(negedge clk);
        score_valid = 1'b1; score_val = s; score_dist = d; score_last = last;
        while (!score_ready && n < 20) begin @(negedge clk); n++; end
        chk("score_ready_wait", 32'(score_ready), 32'd1);
        @(posedge clk); #1;
        score_valid = 1'b0; score_last = 1'b0;
        if (last) chk("beat_lat", 32'(f_valid), 32'd1);
    endtask

    task automatic expect_f(input string nm, input logic [31:0] ef, input logic [15:0] ep,
                            input logic [15:0] ei);
        int n = 0;
        @(negedge clk);
        while (!f_valid && n < 20) begin @(negedge clk); n++; end
        chk({nm, ".f_valid"}, 32'(f_valid), 32'd1);
        chk({nm, ".f_score"}, f_score, ef);
        chk({nm, ".f_pred"}, 32'(f_pred), 32'(ep));
        chk({nm, ".f_idx"}, 32'(f_idx), 32'(ei));
        f_ready = 1'b1;
        @(posedge clk); #1;
        f_ready = 1'b0;
        chk({nm, ".f_drop"}, 32'(f_valid), 32'd0);
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        send_anchor(v.w, v.np, v.clr);
        for (int b = 0; b < v.nb; b++)
            send_beat(v.sv[b], v.sd[b], b == v.nb - 1);
        expect_f(nm, v.ef, v.ep, v.ei);
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, ".anchor_ready"}, 32'(anchor_ready), 32'd1);
        chk({nm, ".score_ready"}, 32'(score_ready), 32'd0);
        chk({nm, ".f_valid"}, 32'(f_valid), 32'd0);
        chk({nm, ".f_score"}, f_score, 32'd0);
        chk({nm, ".f_pred"}, 32'(f_pred), 32'h0000_FFFF);
        chk({nm, ".f_idx"}, 32'(f_idx), 32'd0);
    endtask

    initial begin
        reset = 1'b1; chain_clear = 1'b0; anchor_valid = 1'b0; anchor_w = '0; anchor_nopred = 1'b0;
        score_valid = 1'b0; score_val = '0; score_dist = '0; score_last = 1'b0; f_ready = 1'b0;

        // Ring after tab1: [0]=15 [1]=25 [2]=15 [3]=30 [4]=7FFFFFF0 [5]=7FFFFFFF
        tab1.push_back(mkv(32'd15, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0, 32'd15, 16'hFFFF, 16'd0));
        tab1.push_back(mkv(32'd15, 1'b0, 1'b0, 1, 32'd10, 16'd1, 0, 0, 0, 0, 32'd25, 16'd0, 16'd1));
        tab1.push_back(mkv(32'd15, 1'b0, 1'b0, 1, 32'hFFFF_FFEC, 16'd1, 0, 0, 0, 0,
                           32'd15, 16'hFFFF, 16'd2));
        tab1.push_back(mkv(32'd0, 1'b0, 1'b0, 3, 32'd15, 16'd1, 32'd5, 16'd2, 32'h8000_0000, 16'd3,
                           32'd30, 16'd2, 16'd3));
        tab1.push_back(mkv(32'h7FFF_FFF0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0,
                           32'h7FFF_FFF0, 16'hFFFF, 16'd4));
        tab1.push_back(mkv(32'd0, 1'b0, 1'b0, 1, 32'h0000_0100, 16'd1, 0, 0, 0, 0,
                           32'h7FFF_FFFF, 16'd4, 16'd5));

        // i=70: dist=0 and dist=65 would win if not masked; dist=64 reads f(6)=6.
        tab2.push_back(mkv(32'd0, 1'b0, 1'b0, 3, 32'd1000, 16'd0, 32'd1000, 16'd65, 32'd10, 16'd64,
                           32'd16, 16'd6, 16'd70));
        // Clear with the anchor: it becomes index 0 and dist=1 is out of range.
        tab2.push_back(mkv(32'd7, 1'b0, 1'b1, 1, 32'd1000, 16'd1, 0, 0, 0, 0,
                           32'd7, 16'hFFFF, 16'd0));

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_reset_state("rst");

        foreach (tab1[k]) run_vec($sformatf("tab1_%0d", k), tab1[k]);

        for (int k = 6; k < 70; k++) begin
            send_anchor(32'(k), 1'b1, 1'b0);
            expect_f($sformatf("fill_%0d", k), 32'(k), 16'hFFFF, 16'(k));
        end

        foreach (tab2[k]) run_vec($sformatf("tab2_%0d", k), tab2[k]);

        // Backpressure on index 1; chain_clear during EMIT must be ignored.
        send_anchor(32'd3, 1'b0, 1'b0);
        send_beat(32'd4, 16'd1, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chain_clear = 1'b1;
            score_valid = 1'b1; score_val = 32'd999; score_dist = 16'd1; score_last = 1'b1;
            chk("hold.f_valid", 32'(f_valid), 32'd1);
            chk("hold.f_score", f_score, 32'd11);
            chk("hold.f_pred", 32'(f_pred), 32'd0);
            chk("hold.f_idx", 32'(f_idx), 32'd1);
            chk("hold.score_ready", 32'(score_ready), 32'd0);
            chk("hold.anchor_ready", 32'(anchor_ready), 32'd0);
        end
        chain_clear = 1'b0; score_valid = 1'b0; score_last = 1'b0;
        expect_f("hold_rel", 32'd11, 16'd0, 16'd1);
        send_anchor(32'd2, 1'b1, 1'b0);
        expect_f("after_clear_ignored", 32'd2, 16'hFFFF, 16'd2);

        // Reset in the middle of an accumulation drops the anchor.
        send_anchor(32'd9, 1'b0, 1'b0);
        send_beat(32'd5, 16'd1, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_reset_state("midrst");
        send_anchor(32'd4, 1'b1, 1'b0);
        expect_f("post_rst0", 32'd4, 16'hFFFF, 16'd0);
        send_anchor(32'd0, 1'b0, 1'b0);
        send_beat(32'd1, 16'd1, 1'b1);
        expect_f("post_rst1", 32'd5, 16'd0, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
